// File: rtl/instr_fetch.sv
// instr_fetch: instruction-fetch stage with a one-entry IF/ID register.
//
// A three-state controller (BOOT, RUN, HALTED) steps a word-aligned PC
// through instruction memory. Each fetched word is captured into the IF/ID
// register together with its fetch address + 4. Redirects from downstream
// replace the PC and inject a bubble. Stalls freeze everything. A
// HALT_INSTR word parks the PC until the next redirect.
//
// Ports:
//   clk          in   sole clock, rising edge
//   rst_n        in   synchronous active-low reset
//   pc_addr      out  [31:0] word-aligned fetch address to instruction memory
//   instr        in   [31:0] memory word for pc_addr, same cycle
//   stall        in   hold PC and IF/ID register
//   redirect     in   load PC from redirect_pc and insert a bubble
//   redirect_pc  in   [31:0] redirect target, low two bits ignored
//   if_id_instr  out  [31:0] latched instruction
//   if_id_pc4    out  [31:0] latched fetch address + 4
//   if_id_valid  out  IF/ID entry holds a real instruction
//   halted       out  high while parked in HALTED
//   fetch_count  out  [31:0] number of valid IF/ID loads, wraps
module instr_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] pc_addr,
  input  logic [31:0] instr,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] pc_r;
  logic [31:0] if_id_instr_r;
  logic [31:0] if_id_pc4_r;
  logic        if_id_valid_r;
  logic        halted_r;
  logic [31:0] fetch_count_r;

  logic [31:0] pc_plus4_s;
  logic [31:0] redirect_target_s;
  logic        is_halt_s;

  // Next sequential address, aligned redirect target and halt-word detect.
  always_comb begin
    pc_plus4_s        = pc_r + 32'd4;
    redirect_target_s = redirect_pc & 32'hFFFF_FFFC;
    if (instr == HALT_INSTR) begin
      is_halt_s = 1'b1;
    end else begin
      is_halt_s = 1'b0;
    end
  end

  // Fetch controller, PC and IF/ID register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r       <= BOOT;
      pc_r          <= RESET_PC & 32'hFFFF_FFFC;
      if_id_instr_r <= 32'h0000_0000;
      if_id_pc4_r   <= 32'h0000_0000;
      if_id_valid_r <= 1'b0;
      halted_r      <= 1'b0;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        BOOT: begin
          // One settling cycle; redirect is deliberately not honoured here.
          state_r <= RUN;
        end
        RUN, HALTED: begin
          if (redirect) begin
            // Redirect beats stall and also releases a halt fetched on a
            // wrong path. if_id_pc4 is left as-is since the entry is invalid.
            state_r       <= RUN;
            pc_r          <= redirect_target_s;
            if_id_instr_r <= 32'h0000_0000;
            if_id_valid_r <= 1'b0;
            halted_r      <= 1'b0;
          end else if (stall) begin
            state_r <= state_r;
          end else if (state_r == RUN) begin
            if_id_instr_r <= instr;
            if_id_pc4_r   <= pc_plus4_s;
            if_id_valid_r <= 1'b1;
            fetch_count_r <= fetch_count_r + 32'd1;
            if (is_halt_s) begin
              // PC stays on the halt word so a later redirect is the only exit.
              state_r  <= HALTED;
              halted_r <= 1'b1;
            end else begin
              pc_r <= pc_plus4_s;
            end
          end else begin
            // Parked: drain the halt word out of IF/ID, hold the PC.
            if_id_valid_r <= 1'b0;
          end
        end
        default: begin
          state_r       <= BOOT;
          pc_r          <= RESET_PC & 32'hFFFF_FFFC;
          if_id_valid_r <= 1'b0;
          halted_r      <= 1'b0;
        end
      endcase
    end
  end

  assign pc_addr     = pc_r;
  assign if_id_instr = if_id_instr_r;
  assign if_id_pc4   = if_id_pc4_r;
  assign if_id_valid = if_id_valid_r;
  assign halted      = halted_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch. Instruction memory returns the word index
// (address >> 2) for every address, except 0x20 which returns the halt word
// once halt_en is set. Each step drives inputs, queues the expected outputs
// after the coming edge, then pops and compares them just after that edge.
module tb_instr_fetch;

  typedef struct {
    logic [31:0] pc_addr;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        halted;
    logic [31:0] cnt;
    logic        chk_pc4;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_addr;
  logic [31:0] instr;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        halted;
  logic [31:0] fetch_count;
  logic        halt_en;

  int   tests;
  int   fails;
  exp_t sb[$];

  instr_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc_addr     (pc_addr),
    .instr       (instr),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign instr = (halt_en && pc_addr == 32'h0000_0020) ? 32'hFFFF_FFFF
                                                       : {2'b00, pc_addr[31:2]};

  function automatic exp_t mk(logic [31:0] pc, logic [31:0] ins, logic [31:0] p4,
                              logic v, logic h, logic [31:0] c, logic cp4);
    exp_t e;
    e.pc_addr = pc; e.instr = ins; e.pc4 = p4;
    e.valid = v; e.halted = h; e.cnt = c; e.chk_pc4 = cp4;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests++;
    assert (obs === exp_v) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue expectation, compare after the edge.
  task automatic step(input logic r, input logic s, input logic rd,
                      input logic [31:0] rpc, input exp_t e);
    exp_t got;
    @(negedge clk);
    rst_n = r; stall = s; redirect = rd; redirect_pc = rpc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("pc_addr", pc_addr, got.pc_addr);
    chk("if_id_instr", if_id_instr, got.instr);
    if (got.chk_pc4) chk("if_id_pc4", if_id_pc4, got.pc4);
    chk("if_id_valid", {31'd0, if_id_valid}, {31'd0, got.valid});
    chk("halted", {31'd0, halted}, {31'd0, got.halted});
    chk("fetch_count", fetch_count, got.cnt);
  endtask

  initial begin
    tests = 0; fails = 0;
    halt_en = 1'b0;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;

    // Reset overrides a simultaneous redirect.
    step(1'b0, 1'b0, 1'b1, 32'h0000_0055, mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1));
    step(1'b0, 1'b1, 1'b0, 32'h0000_0000, mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1));
    // BOOT ignores redirect and latches nothing.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0080, mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1));
    // Sequential fetch: pc4 4,8,12,16.
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h04, 32'h0, 32'h04, 1'b1, 1'b0, 32'd1, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h08, 32'h1, 32'h08, 1'b1, 1'b0, 32'd2, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h0C, 32'h2, 32'h0C, 1'b1, 1'b0, 32'd3, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h10, 32'h3, 32'h10, 1'b1, 1'b0, 32'd4, 1'b1));
    // Stall three cycles at 0x10.
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b0, 32'h0, mk(32'h10, 32'h3, 32'h10, 1'b1, 1'b0, 32'd4, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h14, 32'h4, 32'h14, 1'b1, 1'b0, 32'd5, 1'b1));
    // Redirect with stall, misaligned target.
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103, mk(32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 32'd5, 1'b0));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h104, 32'h40, 32'h104, 1'b1, 1'b0, 32'd6, 1'b1));
    // Walk into the halt word at 0x20.
    halt_en = 1'b1;
    step(1'b1, 1'b0, 1'b1, 32'h0000_0018, mk(32'h18, 32'h0, 32'h0, 1'b0, 1'b0, 32'd6, 1'b0));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h1C, 32'h6, 32'h1C, 1'b1, 1'b0, 32'd7, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h20, 32'h7, 32'h20, 1'b1, 1'b0, 32'd8, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h20, 32'hFFFF_FFFF, 32'h24, 1'b1, 1'b1, 32'd9, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h20, 32'hFFFF_FFFF, 32'h24, 1'b0, 1'b1, 32'd9, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h20, 32'hFFFF_FFFF, 32'h24, 1'b0, 1'b1, 32'd9, 1'b1));
    // Redirect out of HALTED to 0x40.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0040, mk(32'h40, 32'h0, 32'h0, 1'b0, 1'b0, 32'd9, 1'b0));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h44, 32'h10, 32'h44, 1'b1, 1'b0, 32'd10, 1'b1));
    // PC wrap at the top of the address space.
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, mk(32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0, 1'b0, 32'd10, 1'b0));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h0, 32'h3FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'd11, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 32'd12, 1'b1));
    // Halt again, then reset while HALTED under stall.
    step(1'b1, 1'b0, 1'b1, 32'h0000_0020, mk(32'h20, 32'h0, 32'h0, 1'b0, 1'b0, 32'd12, 1'b0));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h20, 32'hFFFF_FFFF, 32'h24, 1'b1, 1'b1, 32'd13, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h20, 32'hFFFF_FFFF, 32'h24, 1'b0, 1'b1, 32'd13, 1'b1));
    step(1'b0, 1'b1, 1'b0, 32'h0, mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'd0, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h4, 32'h0, 32'h4, 1'b1, 1'b0, 32'd1, 1'b1));
    step(1'b1, 1'b0, 1'b0, 32'h0, mk(32'h8, 32'h1, 32'h8, 1'b1, 1'b0, 32'd2, 1'b1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
